// File: rtl/chronos_mem_pkg.sv
// Shared types for the core memory-port arbiter: FSM states, owner ids, access sizes.
// Latency: n/a (types and a pure combinational helper only).
// Backpressure: n/a.
package chronos_mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2,
        ST_ERR  = 2'd3
    } state_e;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_DM = 1'b1
    } owner_e;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    // Halfwords need addr[0]==0, words need addr[1:0]==0; bytes never fault.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        logic mis;
        mis = 1'b0;
        case (size)
            SZ_H:    mis = addr_lo[0];
            SZ_W:    mis = |addr_lo;
            default: mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Chooses which requester gets the memory port when the arbiter is free to grant.
// Latency: purely combinational.
// Backpressure: none; the caller qualifies the result with its own accept condition.
// CHRONOS_ARB_RR_EN selects alternating priority on contention; otherwise data always wins.
module mem_arb_pick
    import chronos_mem_pkg::*;
(
    input  logic if_req,
    input  logic dm_req,
`ifdef CHRONOS_ARB_RR_EN
    input  logic last_grant,
`endif
    output logic gnt_if,
    output logic gnt_dm
);

    // One-hot pick; a lone requester always wins, contention goes to the policy.
    always_comb begin
        gnt_if = 1'b0;
        gnt_dm = 1'b0;
        if (if_req && dm_req) begin
`ifdef CHRONOS_ARB_RR_EN
            if (last_grant == OWN_DM) begin
                gnt_if = 1'b1;
            end else begin
                gnt_dm = 1'b1;
            end
`else
            gnt_dm = 1'b1;
`endif
        end else begin
            gnt_if = if_req;
            gnt_dm = dm_req;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between fetch and data requesters, one transaction in flight.
// Latency: grant t, mem_req t+1, owner rvalid one cycle after mem_rvalid; misaligned data errors at t+1.
// Backpressure: requesters hold until gnt; mem_req held until mem_ready. Macro: CHRONOS_ARB_RR_EN.
module mem_port_arbiter
    import chronos_mem_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              if_flush,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [1:0]        dm_size,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic              dm_gnt,
    output logic              dm_rvalid,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [1:0]        mem_size,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ready,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata
);

    state_e            state_q, state_d;
    owner_e            owner_q, owner_d;
    logic              discard_q, discard_d;
    logic              mem_we_q, mem_we_d;
    logic [1:0]        mem_size_q, mem_size_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              if_rvalid_q, if_rvalid_d;
    logic              dm_rvalid_q, dm_rvalid_d;
    logic              dm_err_q, dm_err_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
`ifdef CHRONOS_ARB_RR_EN
    owner_e            last_grant_q, last_grant_d;
`endif

    logic accept;
    logic pick_if;
    logic pick_dm;
    logic dm_mis;

    // ERR is the cycle the error response is presented, so it arbitrates like IDLE.
    assign accept = rst && ((state_q == ST_IDLE) || (state_q == ST_ERR));
    assign dm_mis = is_misaligned(dm_size, dm_addr[1:0]);

    mem_arb_pick u_pick (
        .if_req     (if_req),
        .dm_req     (dm_req),
`ifdef CHRONOS_ARB_RR_EN
        .last_grant (last_grant_q),
`endif
        .gnt_if     (pick_if),
        .gnt_dm     (pick_dm)
    );

    assign if_gnt    = accept && pick_if;
    assign dm_gnt    = accept && pick_dm;
    assign mem_req   = (state_q == ST_REQ);
    assign mem_we    = mem_we_q;
    assign mem_size  = mem_size_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign if_rvalid = if_rvalid_q;
    assign dm_rvalid = dm_rvalid_q;
    assign dm_err    = dm_err_q;
    assign if_rdata  = if_rvalid_q ? rdata_q : '0;
    assign dm_rdata  = dm_rvalid_q ? rdata_q : '0;

    // Next-state, payload capture, discard tracking and response routing.
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        discard_d   = discard_q;
        mem_we_d    = mem_we_q;
        mem_size_d  = mem_size_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_rvalid_d = 1'b0;
        dm_rvalid_d = 1'b0;
        dm_err_d    = 1'b0;
        rdata_d     = '0;
`ifdef CHRONOS_ARB_RR_EN
        last_grant_d = last_grant_q;
`endif
        case (state_q)
            ST_IDLE, ST_ERR: begin
                state_d   = ST_IDLE;
                discard_d = 1'b0;
                if (dm_gnt) begin
                    owner_d     = OWN_DM;
                    mem_we_d    = dm_we;
                    mem_size_d  = dm_size;
                    mem_addr_d  = dm_addr;
                    mem_wdata_d = dm_wdata;
                    if (dm_mis) begin
                        // Never reaches memory; the error answer is ready next cycle.
                        state_d     = ST_ERR;
                        dm_rvalid_d = 1'b1;
                        dm_err_d    = 1'b1;
                    end else begin
                        state_d = ST_REQ;
                    end
                end else if (if_gnt) begin
                    owner_d     = OWN_IF;
                    mem_we_d    = 1'b0;
                    mem_size_d  = SZ_W;
                    mem_addr_d  = if_addr;
                    mem_wdata_d = '0;
                    state_d     = ST_REQ;
                    discard_d   = if_flush;
                end
`ifdef CHRONOS_ARB_RR_EN
                if (dm_gnt) begin
                    last_grant_d = OWN_DM;
                end else if (if_gnt) begin
                    last_grant_d = OWN_IF;
                end
`endif
            end
            ST_REQ: begin
                if (owner_q == OWN_IF && if_flush) begin
                    discard_d = 1'b1;
                end
                if (mem_ready) begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                if (mem_rvalid) begin
                    state_d   = ST_IDLE;
                    discard_d = 1'b0;
                    if (owner_q == OWN_DM) begin
                        dm_rvalid_d = 1'b1;
                        rdata_d     = mem_we_q ? '0 : mem_rdata;
                    end else if (!(discard_q || if_flush)) begin
                        // A flush in the response cycle itself still kills the fetch.
                        if_rvalid_d = 1'b1;
                        rdata_d     = mem_rdata;
                    end
                end else if (owner_q == OWN_IF && if_flush) begin
                    discard_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and output registers; reset abandons any in-flight transaction.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            owner_q     <= OWN_IF;
            discard_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_size_q  <= 2'b00;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_rvalid_q <= 1'b0;
            dm_rvalid_q <= 1'b0;
            dm_err_q    <= 1'b0;
            rdata_q     <= '0;
`ifdef CHRONOS_ARB_RR_EN
            last_grant_q <= OWN_IF;
`endif
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            discard_q   <= discard_d;
            mem_we_q    <= mem_we_d;
            mem_size_q  <= mem_size_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_rvalid_q <= if_rvalid_d;
            dm_rvalid_q <= dm_rvalid_d;
            dm_err_q    <= dm_err_d;
            rdata_q     <= rdata_d;
`ifdef CHRONOS_ARB_RR_EN
            last_grant_q <= last_grant_d;
`endif
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomised bench for mem_port_arbiter with a transaction-level scoreboard.
// Latency: stimulus at posedge+1, monitor samples at negedge.
// Backpressure: random mem_ready stalls and random response latency from the memory model.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req, if_flush, dm_req, dm_we;
    logic [31:0] if_addr, dm_addr, dm_wdata, mem_rdata;
    logic [1:0]  dm_size;
    logic        mem_ready, mem_rvalid;
    logic        if_gnt, if_rvalid, dm_gnt, dm_rvalid, dm_err;
    logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata;
    logic        mem_req, mem_we;
    logic [1:0]  mem_size;

    mem_port_arbiter dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
        .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .dm_req(dm_req), .dm_we(dm_we), .dm_size(dm_size), .dm_addr(dm_addr),
        .dm_wdata(dm_wdata), .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid),
        .dm_rdata(dm_rdata), .dm_err(dm_err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_size(mem_size),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ready(mem_ready),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        logic        err;
        logic [31:0] data;
    } rsp_t;

    rsp_t if_q[$];
    rsp_t dm_q[$];
    rsp_t e;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    // Reference model: port ownership at transaction level.
    logic        busy = 1'b0;
    int          free_at = 0;
    logic        pend_v = 1'b0;
    int          pend_cyc = 0;
    logic        pend_dm, pend_we;
    logic [1:0]  pend_size;
    logic [31:0] pend_addr, pend_wdata;
    logic        cur_v = 1'b0;
    logic        cur_dm, cur_we;
    logic        flushed = 1'b0;
    logic        rst_prev = 1'b1;
`ifdef CHRONOS_ARB_RR_EN
    logic        last_dm = 1'b0;
`endif

    // Handshake between monitor and drivers, plus memory responder state.
    logic if_got = 1'b0;
    logic dm_got = 1'b0;
    int   rv_cnt = 0;
    logic outstanding = 1'b0;
    logic acc_now = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: bound expired, got timeout expected completion (cycle %0d)", name, cyc);
    endtask

    function automatic logic misal(input logic [1:0] s, input logic [31:0] a);
        return (s == 2'd1 && (a % 2) != 0) || (s == 2'd2 && (a % 4) != 0);
    endfunction

    function automatic void clear_model();
        if_q.delete();
        dm_q.delete();
        busy    = 1'b0;
        free_at = 0;
        pend_v  = 1'b0;
        cur_v   = 1'b0;
        flushed = 1'b0;
`ifdef CHRONOS_ARB_RR_EN
        last_dm = 1'b0;
`endif
    endfunction

    // Monitor / scoreboard: compares DUT outputs with the model every negedge.
    always @(negedge clk) begin
        logic exp_now, gi, gd, free;
        cyc++;
        if (!rst_prev) begin
            check("rst_ctrl", {mem_req, mem_we, mem_size, if_rvalid, dm_rvalid, dm_err}, '0);
            check("rst_addr", mem_addr, '0);
            check("rst_data", {if_rdata, dm_rdata | mem_wdata}, '0);
        end
        if (!rst) begin
            check("rst_gnt", {if_gnt, dm_gnt}, '0);
            clear_model();
        end else begin
            exp_now = (if_q.size() > 0) && (if_q[0].cyc == cyc);
            check("if_rvalid", if_rvalid, exp_now);
            if (exp_now) begin
                e = if_q.pop_front();
                if (if_rvalid) check("if_rdata", if_rdata, e.data);
            end
            exp_now = (dm_q.size() > 0) && (dm_q[0].cyc == cyc);
            check("dm_rvalid", dm_rvalid, exp_now);
            if (exp_now) begin
                e = dm_q.pop_front();
                if (dm_rvalid) begin
                    check("dm_err", dm_err, e.err);
                    check("dm_rdata", dm_rdata, e.data);
                end
            end

            check("mem_req", mem_req, pend_v && (cyc > pend_cyc));

            if (if_flush && ((pend_v && !pend_dm) || (cur_v && !cur_dm))) flushed = 1'b1;

            if (mem_rvalid && cur_v) begin
                if (cur_dm) dm_q.push_back('{cyc + 1, 1'b0, cur_we ? 32'h0 : mem_rdata});
                else if (!flushed) if_q.push_back('{cyc + 1, 1'b0, mem_rdata});
                cur_v   = 1'b0;
                busy    = 1'b0;
                free_at = cyc + 1;
            end

            if (mem_req && mem_ready && pend_v && (cyc > pend_cyc)) begin
                check("mem_we", mem_we, pend_we);
                check("mem_size", mem_size, pend_size);
                check("mem_addr", mem_addr, pend_addr);
                check("mem_wdata", mem_wdata, pend_wdata);
                cur_v  = 1'b1;
                cur_dm = pend_dm;
                cur_we = pend_we;
                pend_v = 1'b0;
            end

            free = !busy && (cyc >= free_at);
            gi = 1'b0;
            gd = 1'b0;
            if (free) begin
                if (if_req && dm_req) begin
`ifdef CHRONOS_ARB_RR_EN
                    if (last_dm) gi = 1'b1;
                    else gd = 1'b1;
`else
                    gd = 1'b1;
`endif
                end else begin
                    gi = if_req;
                    gd = dm_req;
                end
            end
            check("gnt", {if_gnt, dm_gnt}, {gi, gd});

            if (gd) begin
`ifdef CHRONOS_ARB_RR_EN
                last_dm = 1'b1;
`endif
                if (misal(dm_size, dm_addr)) begin
                    dm_q.push_back('{cyc + 1, 1'b1, 32'h0});
                    free_at = cyc + 1;
                end else begin
                    busy = 1'b1; pend_v = 1'b1; pend_cyc = cyc; pend_dm = 1'b1;
                    pend_we = dm_we; pend_size = dm_size; pend_addr = dm_addr; pend_wdata = dm_wdata;
                end
            end else if (gi) begin
`ifdef CHRONOS_ARB_RR_EN
                last_dm = 1'b0;
`endif
                busy = 1'b1; pend_v = 1'b1; pend_cyc = cyc; pend_dm = 1'b0;
                pend_we = 1'b0; pend_size = 2'd2; pend_addr = if_addr; pend_wdata = 32'h0;
                flushed = if_flush;
            end
        end
        if (if_gnt) if_got = 1'b1;
        if (dm_gnt) dm_got = 1'b1;
        rst_prev = rst;
    end

    // One clock of stimulus: memory responder, requesters and flush noise.
    task automatic step(input logic allow);
        @(posedge clk);
        #1;
        mem_rvalid = 1'b0;
        mem_rdata  = 32'h0;
        if (rv_cnt > 0) begin
            rv_cnt--;
            if (rv_cnt == 0) begin
                mem_rvalid  = 1'b1;
                mem_rdata   = $urandom;
                outstanding = 1'b0;
            end
        end else if (!outstanding && ($urandom % 40 == 0)) begin
            mem_rvalid = 1'b1;
            mem_rdata  = $urandom;
        end
        mem_ready = ($urandom % 3 != 0);
        acc_now   = 1'b0;
        if (mem_req && mem_ready) begin
            rv_cnt      = 1 + $urandom % 4;
            outstanding = 1'b1;
            acc_now     = 1'b1;
        end

        if (if_got) if_req = 1'b0;
        if_got = 1'b0;
        if (!if_req && allow && ($urandom % 100 < 45)) begin
            if_req  = 1'b1;
            if_addr = $urandom & 32'h0000_0FFC;
        end
        if (dm_got) dm_req = 1'b0;
        dm_got = 1'b0;
        if (!dm_req && allow && ($urandom % 100 < 40)) begin
            dm_req   = 1'b1;
            dm_we    = $urandom % 2;
            dm_size  = 2'($urandom % 3);
            dm_addr  = 32'h200 + ($urandom % 16);
            dm_wdata = $urandom;
        end
        if_flush = ($urandom % 100 < 8);
    endtask

    initial begin
        logic hit;
        rst = 1'b0;
        if_req = 1'b0; if_flush = 1'b0; if_addr = '0;
        dm_req = 1'b0; dm_we = 1'b0; dm_size = 2'b00; dm_addr = '0; dm_wdata = '0;
        mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;

        for (int i = 0; i < 1500; i++) step(1'b1);

        // Pull reset while a transaction waits for its response.
        hit = 1'b0;
        for (int i = 0; i < 400 && !hit; i++) begin
            step(1'b1);
            if (outstanding && rv_cnt >= 2 && !acc_now) hit = 1'b1;
        end
        if (!hit) fail("reset_in_resp");
        rst = 1'b0;
        step(1'b1);
        step(1'b1);
        rst = 1'b1;

        for (int i = 0; i < 1500; i++) step(1'b1);

        hit = 1'b0;
        for (int i = 0; i < 400 && !hit; i++) begin
            step(1'b0);
            if (!if_req && !dm_req && !busy && !outstanding && rv_cnt == 0) hit = 1'b1;
        end
        if (!hit) fail("drain");
        repeat (4) step(1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
